polo_sequencer: RTL and testbench
=================================

# polo_sequencer

Streams the fixed reply string "POLO" (optionally followed by CR LF) byte-by-byte into uart_tx after each match pulse from buffer_comparator. Sits between buffer_comparator (upstream, trigger source) and uart_tx (downstream, byte transmitter). It handles the per-byte start/busy handshake, queues one trigger that arrives while a reply is in flight, and flags a transmitter that never acknowledges.

## Interface
- ACK_TIMEOUT, 16: cycles to wait for tx_busy to rise after tx_start before aborting (≥2).
- CNT_W, 5: width of the ack-timeout counter; must hold ACK_TIMEOUT-1.
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset, synchronous, active-low.
- trigger  in  1  one-cycle match pulse from buffer_comparator.
- tx_busy  in  1  busy flag from uart_tx.
- tx_data  out  8  byte presented to uart_tx; stable from tx_start until tx_busy falls.
- tx_start  out  1  one-cycle send pulse to uart_tx.
- seq_busy  out  1  high while a reply is in progress (any state except IDLE).
- seq_done  out  1  one-cycle pulse after the last byte's tx_busy falls.
- seq_error  out  1  sticky ack-timeout flag; cleared when the next trigger is accepted.

## Operation
- States: IDLE, WAIT_ACK, WAIT_DONE. Byte index idx (3 bits) selects the message byte. MSG_LEN is 6 with CRLF, 4 without.
- IDLE: on trigger=1 or pending=1 → idx=0, tx_data=0x50 ('P'), tx_start=1, seq_error=0, pending=0, cnt=0 → WAIT_ACK.
- WAIT_ACK: tx_start=0 after one cycle. If tx_busy=1 → WAIT_DONE. Else cnt++. If cnt reaches ACK_TIMEOUT-1 → seq_error=1, idx=0 → IDLE. No seq_done is issued.
- WAIT_DONE: when tx_busy=0 and idx==MSG_LEN-1 → seq_done=1 → IDLE. When tx_busy=0 and idx<MSG_LEN-1 → idx++, tx_data=next byte, tx_start=1, cnt=0 → WAIT_ACK.
- Message bytes: 0x50 0x4F 0x4C 0x4F, then 0x0D 0x0A when configured.
- Pending: trigger while seq_busy=1 sets pending=1. It is one-deep; further triggers are dropped. A trigger in IDLE coincident with pending=1 is consumed once.
- Pending survives a timeout abort; the retry starts from the IDLE cycle that follows.
- Reset values: tx_data=0x00, tx_start=0, seq_busy=0, seq_done=0, seq_error=0, pending=0, idx=0, cnt=0, state=IDLE.

## Timing
- Trigger sampled high at edge N in IDLE → tx_start=1, tx_data=0x50 visible after edge N. tx_start is back to 0 after edge N+1.
- seq_busy is registered and goes high after edge N.
- Inter-byte: tx_busy sampled low at edge M → next tx_start visible after edge M (zero idle cycles).
- seq_done is visible after the edge that samples the final tx_busy low. seq_busy=0 in the same cycle.
- Pending restart: tx_start for the new 'P' is visible one cycle after seq_done.
- Timeout: with tx_busy stuck low, seq_error rises ACK_TIMEOUT cycles after tx_start.
- Reset mid-reply: all outputs take their reset values after the first edge with rst_n=0, including a pending trigger.

## Configuration
- POLO_CRLF_EN defined: MSG_LEN=6; CR LF are appended.
- POLO_CRLF_EN undefined: MSG_LEN=4; seq_done follows the second 'O'.
- Handshake and timing are otherwise identical.

## Structure
- Shared package polo_pkg holds:
  - the state enum typedef (IDLE/WAIT_ACK/WAIT_DONE);
  - the MSG_LEN localparam (conditional on POLO_CRLF_EN);
  - the byte constants CH_P, CH_O, CH_L, CH_CR, CH_LF.
- Sub-module polo_msg_rom: combinational idx→byte lookup, so the message is editable in one place.
- The FSM, counter and pending flag live in polo_sequencer.

## Test plan
- Trigger once, model uart_tx with busy high 2 cycles after start for 20 cycles → bytes 50 4F 4C 4F 0D 0A in order, 6 tx_start pulses, one seq_done, seq_error=0.
- Second trigger during byte 2, third during byte 4 → exactly two complete replies (12 bytes). The second 'P' start comes one cycle after the first seq_done.
- tx_busy held low, ACK_TIMEOUT=16 → one tx_start, seq_error=1 at cycle 16, no seq_done, seq_busy=0. A following trigger clears seq_error.
- rst_n low for 1 cycle during WAIT_DONE of byte 3 with pending set → all outputs at reset values. No further tx_start until a new trigger arrives.
- Build without POLO_CRLF_EN → 4 bytes 50 4F 4C 4F, then seq_done.
- tx_data stability: check tx_data is unchanged from each tx_start until the corresponding tx_busy fall.

Source files
------------

// File: rtl/polo_pkg.sv
// Shared types and message constants for the POLO reply sequencer.
// Define POLO_CRLF_EN to append CR LF to the reply.
package polo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      WAIT_DONE
   } state_e;

`ifdef POLO_CRLF_EN
   localparam int MSG_LEN = 6;
`else
   localparam int MSG_LEN = 4;
`endif

   localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

   localparam logic [7:0] CH_P  = 8'h50;
   localparam logic [7:0] CH_O  = 8'h4F;
   localparam logic [7:0] CH_L  = 8'h4C;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

endpackage

// File: rtl/polo_msg_rom.sv
// Byte index to reply character lookup; MSG_LEN limits how much is sent.
// Contents are independent of POLO_CRLF_EN.
module polo_msg_rom
   import polo_pkg::*;
(
   input  logic [2:0] idx,
   output logic [7:0] data
);

   always_comb begin
      data = 8'h00;
      case (idx)
         3'd0:    data = CH_P;
         3'd1:    data = CH_O;
         3'd2:    data = CH_L;
         3'd3:    data = CH_O;
         3'd4:    data = CH_CR;
         3'd5:    data = CH_LF;
         default: data = 8'h00;
      endcase
   end

endmodule

// File: rtl/polo_sequencer.sv
// Streams "POLO" (plus CR LF when POLO_CRLF_EN is defined) into uart_tx
// per trigger, with one-deep trigger queueing and an ack timeout.
module polo_sequencer
   import polo_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trigger,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       seq_busy,
   output logic       seq_done,
   output logic       seq_error
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_start_q, tx_start_d;
   logic             seq_done_q, seq_done_d;
   logic             seq_error_q, seq_error_d;

   logic [2:0]       rom_idx;
   logic [7:0]       rom_byte;

   // The ROM always looks up the byte that would be launched next.
   assign rom_idx = (state_q == IDLE) ? 3'd0 : idx_q + 3'd1;

   polo_msg_rom u_rom (
      .idx  (rom_idx),
      .data (rom_byte)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      pending_d   = pending_q;
      tx_data_d   = tx_data_q;
      tx_start_d  = 1'b0;
      seq_done_d  = 1'b0;
      seq_error_d = seq_error_q;

      if (state_q != IDLE && trigger)
         pending_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (trigger || pending_q) begin
               idx_d       = 3'd0;
               tx_data_d   = rom_byte;
               tx_start_d  = 1'b1;
               seq_error_d = 1'b0;
               pending_d   = 1'b0;
               cnt_d       = '0;
               state_d     = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CNT_MAX) begin
               seq_error_d = 1'b1;
               idx_d       = 3'd0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (idx_q == LAST_IDX) begin
                  seq_done_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  idx_d      = idx_q + 3'd1;
                  tx_data_d  = rom_byte;
                  tx_start_d = 1'b1;
                  cnt_d      = '0;
                  state_d    = WAIT_ACK;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= 3'd0;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         seq_done_q  <= 1'b0;
         seq_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         seq_done_q  <= seq_done_d;
         seq_error_q <= seq_error_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign seq_busy  = (state_q != IDLE);
   assign seq_done  = seq_done_q;
   assign seq_error = seq_error_q;

endmodule

// File: tb/tb_polo_sequencer.sv
// Directed bench for polo_sequencer with a uart_tx stand-in and a
// message-level reply model checked every cycle.
module tb_polo_sequencer;

`ifdef POLO_CRLF_EN
   localparam int MLEN = 6;
`else
   localparam int MLEN = 4;
`endif

   logic       clk;
   logic       rst_n;
   logic       trigger;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       seq_busy;
   logic       seq_done;
   logic       seq_error;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int starts = 0;
   int dones = 0;
   int last_done_cyc = -100;
   int last_p_gap = 0;
   bit uart_en = 1'b1;
   logic [7:0] got[$];
   logic [7:0] msg [6] = '{8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

   polo_sequencer #(.ACK_TIMEOUT(16), .CNT_W(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .trigger   (trigger),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .seq_busy  (seq_busy),
      .seq_done  (seq_done),
      .seq_error (seq_error)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // uart_tx stand-in: busy rises 2 cycles after start, lasts 20 cycles.
   initial begin
      int dly;
      int hold;
      dly = 0;
      hold = 0;
      tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (hold > 0) begin
            hold--;
            if (hold == 0) tx_busy = 1'b0;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               tx_busy = 1'b1;
               hold = 20;
            end
         end else if (tx_start && uart_en) begin
            dly = 2;
         end
      end
   end

   // Reply model: each start from idle is 'P', bytes follow the message
   // in order, and done only ends a full message.
   initial begin
      int   exp_idx;
      bit   hold;
      bit   seen_busy;
      logic [7:0] held;
      logic prev_start;
      logic prev_done;
      exp_idx = 0;
      hold = 0;
      seen_busy = 0;
      held = 8'h00;
      prev_start = 1'b0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_idx = 0;
            hold = 0;
         end else begin
            if (hold && !tx_start) begin
               chk("tx_data_stable", tx_data, held);
               if (tx_busy) seen_busy = 1;
               else if (seen_busy) hold = 0;
            end
            if (seq_done) begin
               chk("done_at_msg_end", exp_idx, 0);
               chk("busy_low_at_done", seq_busy, 0);
               chk("done_one_cycle", prev_done, 0);
               dones++;
               last_done_cyc = cyc;
            end
            if (!seq_busy) begin
               exp_idx = 0;
               hold = 0;
            end
            if (tx_start) begin
               chk("start_busy", seq_busy, 1);
               chk("start_one_cycle", prev_start, 0);
               chk("tx_byte", tx_data, msg[exp_idx]);
               got.push_back(tx_data);
               if (exp_idx == 0) last_p_gap = cyc - last_done_cyc;
               starts++;
               exp_idx = (exp_idx + 1) % MLEN;
               hold = 1;
               held = tx_data;
               seen_busy = 0;
            end
         end
         prev_start = tx_start;
         prev_done = seq_done;
      end
   end

   task automatic pulse();
      @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic wait_starts(int n, string nm);
      int k = 0;
      while (starts < n && k < 2000) begin
         @(posedge clk);
         k++;
      end
      chk(nm, 32'(starts >= n), 1);
   endtask

   task automatic wait_dones(int n, string nm);
      int k = 0;
      while (dones < n && k < 2000) begin
         @(posedge clk);
         k++;
      end
      chk(nm, 32'(dones >= n), 1);
   endtask

   initial begin
      int s0;
      int d0;
      int k;
      rst_n = 1'b0;
      trigger = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_seq_busy", seq_busy, 0);
      chk("rst_seq_done", seq_done, 0);
      chk("rst_seq_error", seq_error, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // single reply
      got.delete();
      pulse();
      chk("t1_start", tx_start, 1);
      chk("t1_first_P", tx_data, 8'h50);
      chk("t1_busy", seq_busy, 1);
      @(negedge clk);
      chk("t1_start_low", tx_start, 0);
      wait_dones(1, "t1_wait_done");
      chk("t1_starts", starts, MLEN);
      chk("t1_dones", dones, 1);
      chk("t1_error", seq_error, 0);
      chk("t1_nbytes", got.size(), MLEN);
      chk("t1_b0", got[0], 8'h50);
      chk("t1_b1", got[1], 8'h4F);
      chk("t1_b2", got[2], 8'h4C);
      chk("t1_b3", got[3], 8'h4F);
`ifdef POLO_CRLF_EN
      chk("t1_b4", got[4], 8'h0D);
      chk("t1_b5", got[5], 8'h0A);
`endif

      // queued trigger plus a dropped one
      repeat (3) @(negedge clk);
      s0 = starts;
      d0 = dones;
      pulse();
      wait_starts(s0 + 2, "t2_wait_b2");
      pulse();
      wait_starts(s0 + 4, "t2_wait_b4");
      pulse();
      wait_dones(d0 + 2, "t2_wait_done2");
      chk("t2_p_gap", last_p_gap, 1);
      repeat (60) @(negedge clk);
      chk("t2_starts", starts - s0, 2 * MLEN);
      chk("t2_dones", dones - d0, 2);

      // ack timeout with tx_busy stuck low
      uart_en = 1'b0;
      s0 = starts;
      d0 = dones;
      pulse();
      chk("t3_start", tx_start, 1);
      k = 0;
      while (!seq_error && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("t3_timeout_cycles", k, 16);
      chk("t3_busy", seq_busy, 0);
      chk("t3_starts", starts - s0, 1);
      chk("t3_no_done", dones - d0, 0);
      pulse();
      chk("t3_err_clear", seq_error, 0);
      chk("t3_restart", tx_start, 1);
      k = 0;
      while (!seq_error && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("t3_timeout2", k, 16);
      uart_en = 1'b1;
      repeat (3) @(negedge clk);

      // reset mid-reply with a trigger pending
      s0 = starts;
      pulse();
      wait_starts(s0 + 3, "t4_wait_b3");
      k = 0;
      while (!tx_busy && k < 40) begin
         @(posedge clk);
         k++;
      end
      chk("t4_busy_seen", tx_busy, 1);
      pulse();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t4_tx_start", tx_start, 0);
      chk("t4_tx_data", tx_data, 8'h00);
      chk("t4_seq_busy", seq_busy, 0);
      chk("t4_seq_done", seq_done, 0);
      chk("t4_seq_error", seq_error, 0);
      rst_n = 1'b1;
      s0 = starts;
      d0 = dones;
      repeat (40) @(negedge clk);
      chk("t4_no_restart", starts - s0, 0);
      pulse();
      chk("t4_new_P", tx_data, 8'h50);
      chk("t4_new_start", tx_start, 1);
      wait_dones(d0 + 1, "t4_wait_done");
      chk("t4_starts", starts - s0, MLEN);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
